// File: rtl/imm_pkg.sv
// Shared immediate types and the RISC-V immediate extraction function.
// imm_extend works on the 25-bit field instr[31:7] and yields a 32-bit value plus an illegal flag.
package imm_pkg;

    localparam int unsigned IMM_W  = 25;
    localparam int unsigned SRC_W  = 3;
    localparam int unsigned BASE_W = 32;

    typedef enum logic [SRC_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    typedef struct packed {
        logic              err;
        logic [BASE_W-1:0] imm;
    } imm_res_t;

    function automatic imm_res_t imm_extend(input logic [IMM_W-1:0] in_imm,
                                            input logic [SRC_W-1:0] in_src);
        logic [BASE_W-1:0] instr;
        imm_res_t          res;
        instr = {in_imm, 7'b0};
        res   = '0;
        case (in_src)
            IMM_I:   res.imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   res.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   res.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            IMM_U:   res.imm = {instr[31:12], 12'b0};
            IMM_J:   res.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: res.err = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_skid.sv
// Two-entry skid buffer: output register plus one overflow entry, strict FIFO order.
// in_ready is a flop so upstream never sees a combinational path from out_ready.
module imm_skid #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t         state;
    occ_t         state_nxt;
    logic [W-1:0] skid_data;
    logic         load_out;
    logic         load_skid;
    logic         pop_skid;
    logic         in_xfer_c;
    logic         out_xfer_c;

    assign in_xfer_c  = in_valid && in_ready;
    assign out_xfer_c = out_valid && out_ready;

    // Occupancy transitions and which register captures data this cycle.
    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer_c) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer_c && out_xfer_c) begin
                    load_out = 1'b1;
                end else if (in_xfer_c) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (out_xfer_c) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer_c) begin
                    state_nxt = ONE;
                    pop_skid  = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            if (load_out) begin
                out_data <= in_data;
            end else if (pop_skid) begin
                out_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: decode immediate field -> XLEN value through a skid buffer.
// Tracks a sticky flag for any illegal immediate type accepted at the input.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [SRC_W-1:0] in_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err,
    output logic             err_sticky
);

    localparam int unsigned PAY_W = XLEN + 1;

    imm_res_t         ext_c;
    logic [XLEN-1:0]  imm_wide_c;
    logic [PAY_W-1:0] pay_in_c;
    logic [PAY_W-1:0] pay_out_c;

    assign ext_c      = imm_extend(in_imm, in_src);
    // Widen by replicating bit 31 of the 32-bit form.
    assign imm_wide_c = XLEN'($signed(ext_c.imm));
    assign pay_in_c   = {ext_c.err, imm_wide_c};
    assign out_err    = pay_out_c[PAY_W-1];
    assign out_imm    = pay_out_c[XLEN-1:0];

    imm_skid #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (pay_in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (pay_out_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (in_valid && in_ready && ext_c.err) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Pipelined, parametrised successor to the single-cycle sign extender. Accepts the 25-bit instruction immediate field (instr[31:7]) plus an immediate-type selector. Produces the XLEN-wide extended immediate through a registered stage with valid/ready handshake and a 2-entry skid buffer. Sits between the decode and execute stages of the pipelined core. Adds S/B types, XLEN=64 and illegal-type flagging.

## Interface
- XLEN, 32: output width; legal values 32 or 64.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has a valid immediate.
- in_ready  output  1  block can accept this cycle.
- in_imm  input  25  instruction bits [31:7]; in_imm[k] = instr[k+7].
- in_src  input  3  type: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 illegal.
- out_valid  output  1  out_imm/out_err valid.
- out_ready  input  1  downstream accepts this cycle.
- out_imm  output  XLEN  extended immediate.
- out_err  output  1  entry had illegal in_src.
- err_sticky  output  1  set on any accepted illegal entry; cleared only by reset.

## Operation
- Extension, in instr-bit terms, result sign-extended from bit 31 of the 32-bit form to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; with XLEN=64, bit 31 replicates into [63:32].
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Illegal: out_imm = 0, out_err = 1.
- Transfer on in: in_valid && in_ready. Transfer on out: out_valid && out_ready.
- Storage: main output register plus one skid entry; 0, 1 or 2 entries held.
- Occupancy states: EMPTY (out_valid=0), ONE (output reg valid), FULL (output reg + skid valid).
  - EMPTY + in xfer → ONE.
  - ONE + in xfer, no out xfer → FULL (new entry to skid).
  - ONE + in xfer + out xfer → ONE (new entry to output reg).
  - ONE + out xfer only → EMPTY.
  - FULL + out xfer → ONE (skid moves to output reg). No in xfer possible in FULL.
- Order strictly FIFO; no entry dropped or duplicated.
- err_sticky sets on the cycle an illegal entry is accepted at the input.

## Timing
- Latency: accepted entry appears on out_* the next cycle when EMPTY, or when ONE with a simultaneous out xfer.
- in_ready = !FULL, driven from a register (no combinational path from out_ready).
- Throughput: one entry per cycle while out_ready held high.
- out_imm/out_err stable while out_valid && !out_ready.
- Reset: state EMPTY; out_valid=0, out_imm=0, out_err=0, err_sticky=0, in_ready=1 on the cycle after reset asserts. Reset mid-operation discards all held entries; reset dominates any simultaneous transfer.
- in_imm/in_src are ignored when in_valid=0.

## Structure
- Shared package imm_pkg: imm_src_t enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J); pure function imm_extend(in_imm, in_src) returning a 32-bit value + err.
- Sub-module imm_skid: generic width-parameterised 2-entry skid buffer holding {err, imm}. The top level does the combinational extension (XLEN widening) into imm_skid and tracks err_sticky.

## Test plan
- XLEN=32, stream with out_ready=1: 0xFFF00093 (I) → 0xFFFFFFFF; 0xFE112E23 (S) → 0xFFFFFFFC; 0x00000463 (B) → 0x00000008; 0x123450B7 (U) → 0x12345000; 0xFFDFF06F (J) → 0xFFFFFFFC. Outputs in order, one per cycle, latency 1.
- XLEN=64: 0x800000B7 (U) → 0xFFFFFFFF80000000; 0xFFF00093 (I) → 0xFFFFFFFFFFFFFFFF.
- Backpressure: out_ready=0, three back-to-back in_valid → two accepted, in_ready=0 from the cycle after the second. Raise out_ready → both emerge in order, third accepted, no loss.
- in_src=3'b101 with any in_imm → out_imm=0, out_err=1, err_sticky=1 and held. A following legal entry has out_err=0, and err_sticky stays 1.
- Reset while FULL → next cycle out_valid=0, in_ready=1, err_sticky=0. The first post-reset entry is the only output.
